pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the 32-bit ALU datapath and its wider variants.
- Stage 1 computes bit-level and group-level generate/propagate. Stage 2 resolves the group carries through a lookahead root, forms the sum, and produces the condition flags.
- Uses a valid/ready handshake on both sides with full backpressure, so it can sit between the operand-fetch and writeback registers.

Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of GROUP and ≥ 8.
- GROUP, 16: width of one leaf lookahead group. Must be a power of 2, ≥ 4, and ≤ WIDTH.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  op[0]: 0 = add, 1 = subtract (A−B). op[1]: saturate request (see Optional Feature).
- cin  input  1  carry-in for add. For subtract the block forces the carry-in to 1 and ignores cin.
- tag_in  input  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH−1].
- tag_out  output  TAG_W  tag of the current result.

Behaviour:
- Reset: v1 = v2 = 0, all data registers = 0.
  - Outputs during reset: out_valid = 0, sum = 0, c_out = ovf = zero = neg = 0, tag_out = 0, in_ready = 1.
  - Reset mid-operation discards both in-flight bundles; no partial result is emitted.
- Operand conditioning: for subtract, B is inverted and the effective carry-in is 1. For add, the effective carry-in is cin.
- Stage 1 register holds:
  - per-bit g = A & B' and p = A ^ B';
  - per-group G/P, computed with the standard lookahead recurrence over GROUP bits;
  - effective carry-in, A MSB, B' MSB, op[1], and the tag.
- Stage 2 register holds:
  - the group carries, resolved from group G/P and carry-in through a single lookahead root over WIDTH/GROUP groups;
  - the in-group carries, the sum (p ^ carry), and the flags.
- Flags:
  - ovf = (A MSB == B' MSB) && (sum MSB != A MSB).
  - zero and neg are computed on the final emitted sum.
- Latency: exactly 2 cycles from the input handshake (in_valid && in_ready) to out_valid, with no stall.
- Throughput: one operation per cycle.
- Handshake:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1. This is combinational from out_ready; no other combinational path runs input to output.
  - Stage 1 loads when adv1. v1 takes in_valid && in_ready.
  - Stage 2 loads from stage 1 when adv2. v2 takes v1.
  - A registered stage holds its data when not advancing.
  - While out_valid is high and out_ready is low, sum, the flags and tag_out are held stable.
- Ordering: strictly in order; tags emerge in acceptance order.
- Boundaries:
  - A full pipe with out_ready low gives in_ready = 0.
  - A full pipe with out_ready high accepts a new bundle and retires one in the same cycle.
  - A bubble (v1 = 0) collapses: a stalled v2 with v1 = 0 still accepts input.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined: when op[1] = 1 and ovf = 1, sum is clamped. A MSB = 0 gives 0111…1; A MSB = 1 gives 1000…0.
  - ovf still reports 1; c_out is unchanged.
  - zero and neg reflect the clamped sum.
- Undefined: op[1] is ignored, sum always wraps, and no clamp logic is present.

Test Plan:
- WIDTH=32, add 0x0000_FFFF + 0x0000_0001, cin=0 → 2 cycles later: sum=0x0001_0000, c_out=0, ovf=0, zero=0. This exercises the group-boundary carry.
- Add 0xFFFF_FFFF + 0x0000_0001 → sum=0, c_out=1, zero=1, ovf=0. Sub 5−7 → sum=0xFFFF_FFFE, c_out=0, neg=1.
- Add 0x7FFF_FFFF + 1 with op=2'b10 → without CLA_SAT_EN: sum=0x8000_0000, ovf=1. With CLA_SAT_EN: sum=0x7FFF_FFFF, ovf=1, neg=0.
- Back-to-back stream of 6 ops with tags 0–5, out_ready low for cycles 3–5:
  - in_ready drops after two bundles are held;
  - outputs stay stable while stalled;
  - tags emerge 0–5 in order with no loss or duplication.
- Assert rst with two bundles in flight → out_valid=0 immediately (asynchronous) and in_ready=1; after release, no stale result appears.
- WIDTH=64, GROUP=8: random add/sub vectors checked against a reference model, plus 0x00FF…FF + 1 carry ripple across all groups.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder -- two-stage pipelined carry-lookahead adder/subtractor.
//
// Stage 1 conditions operand B (inverted for subtract), forms per-bit g/p and
// per-group G/P. Stage 2 resolves group carries through one lookahead root,
// ripples them into each leaf group, forms the sum and the condition flags.
// A valid/ready handshake with full backpressure sits on both sides.
//
// Optional feature: define CLA_SAT_EN to clamp the sum on signed overflow
// when op[1] is set. When it is undefined, op[1] is ignored and the sum wraps.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   a, b                operands (WIDTH)
//   op                  op[0]: 0 add / 1 subtract, op[1]: saturate request
//   cin                 carry-in for add (forced to 1 for subtract)
//   tag_in              sideband tag (TAG_W), returned with the result
//   out_valid/out_ready output handshake
//   sum                 result (WIDTH)
//   c_out, ovf, zero, neg  carry out, signed overflow, sum==0, sum MSB
//   tag_out             tag of the current result

// Group generate/propagate over one leaf group.
module cla_grp_gp #(
    parameter int GROUP = 16
) (
    input  logic [GROUP-1:0] g,
    input  logic [GROUP-1:0] p,
    output logic             gg,
    output logic             gp
);
    always_comb begin
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) gg = g[i] | (p[i] & gg);
        gp = &p;
    end
endmodule

// In-group carries from the group carry-in.
module cla_grp_carry #(
    parameter int GROUP = 16
) (
    input  logic [GROUP-1:0] g,
    input  logic [GROUP-1:0] p,
    input  logic             ci,
    output logic [GROUP-1:0] c
);
    logic cc;
    always_comb begin
        cc = ci;
        for (int i = 0; i < GROUP; i++) begin
            c[i] = cc;
            cc   = g[i] | (p[i] & cc);
        end
    end
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [TAG_W-1:0] tag_out
);
    localparam int NG = WIDTH / GROUP;

    // vld_pipe[1] = stage 1 valid, vld_pipe[2] = stage 2 valid
    logic [2:1] vld_pipe;
    logic       adv1, adv2;

    assign adv2      = !vld_pipe[2] || out_ready;
    assign adv1      = !vld_pipe[1] || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];

    // ---------------- stage 1 combinational ----------------
    logic [WIDTH-1:0] b_eff, g0, p0;
    logic             cin_eff;
    logic [NG-1:0]    gg0, gp0;

    assign b_eff   = op[0] ? ~b : b;
    assign cin_eff = op[0] | cin;
    assign g0      = a & b_eff;
    assign p0      = a ^ b_eff;

    for (genvar j = 0; j < NG; j++) begin : gen_gp
        cla_grp_gp #(.GROUP(GROUP)) u_gp (
            .g  (g0[j*GROUP +: GROUP]),
            .p  (p0[j*GROUP +: GROUP]),
            .gg (gg0[j]),
            .gp (gp0[j])
        );
    end

    // ---------------- stage 1 registers ----------------
    logic [WIDTH-1:0] g1, p1;
    logic [NG-1:0]    gg1, gp1;
    logic             ci1, am1, bm1;
    logic [TAG_W-1:0] tag1;

`ifdef CLA_SAT_EN
    logic sat1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sat1 <= 1'b0;
        else if (adv1) sat1 <= op[1];
    end
`else
    logic unused_sat;
    assign unused_sat = op[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            g1   <= '0;
            p1   <= '0;
            gg1  <= '0;
            gp1  <= '0;
            ci1  <= 1'b0;
            am1  <= 1'b0;
            bm1  <= 1'b0;
            tag1 <= '0;
        end else if (adv1) begin
            vld_pipe[1] <= in_valid;
            g1   <= g0;
            p1   <= p0;
            gg1  <= gg0;
            gp1  <= gp0;
            ci1  <= cin_eff;
            am1  <= a[WIDTH-1];
            bm1  <= b_eff[WIDTH-1];
            tag1 <= tag_in;
        end
    end

    // ---------------- stage 2 combinational ----------------
    // Lookahead root: group carries from group G/P and the effective carry-in.
    logic [NG:0]      gc;
    logic             rc;
    always_comb begin
        rc = ci1;
        for (int k = 0; k < NG; k++) begin
            gc[k] = rc;
            rc    = gg1[k] | (gp1[k] & rc);
        end
        gc[NG] = rc;
    end

    logic [WIDTH-1:0] cvec, sum_raw, sum_n;
    logic             ovf_n;

    for (genvar j = 0; j < NG; j++) begin : gen_carry
        cla_grp_carry #(.GROUP(GROUP)) u_carry (
            .g  (g1[j*GROUP +: GROUP]),
            .p  (p1[j*GROUP +: GROUP]),
            .ci (gc[j]),
            .c  (cvec[j*GROUP +: GROUP])
        );
    end

    assign sum_raw = p1 ^ cvec;
    assign ovf_n   = (am1 == bm1) && (sum_raw[WIDTH-1] != am1);

`ifdef CLA_SAT_EN
    // Clamp toward the sign of A: both operands share that sign on overflow.
    assign sum_n = (sat1 && ovf_n) ? {am1, {(WIDTH-1){~am1}}} : sum_raw;
`else
    assign sum_n = sum_raw;
`endif

    // ---------------- stage 2 registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            tag_out <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            sum     <= sum_n;
            c_out   <= gc[NG];
            ovf     <= ovf_n;
            zero    <= ~|sum_n;
            neg     <= sum_n[WIDTH-1];
            tag_out <= tag1;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: a 32/16 instance for the main
// function, handshake, stall, ordering and reset behaviour, and a 64/8
// instance for wide carry propagation across many leaf groups.
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst;

    // 32-bit instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic [1:0]  op;
    logic        cin, c_out, ovf, zero, neg;
    logic [3:0]  tag_in, tag_out;

    // 64-bit instance
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [63:0] w_a, w_b, w_sum;
    logic [1:0]  w_op;
    logic        w_cin, w_c_out, w_ovf, w_zero, w_neg;
    logic [3:0]  w_tag_in, w_tag_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .GROUP(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg),
        .tag_out(tag_out)
    );

    pipelined_cla_adder #(.WIDTH(64), .GROUP(8), .TAG_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .op(w_op), .cin(w_cin), .tag_in(w_tag_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf), .zero(w_zero), .neg(w_neg),
        .tag_out(w_tag_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    // One operation through the empty 32-bit pipe; result visible on return.
    task automatic send32(input logic [31:0] ta, input logic [31:0] tb2,
                          input logic [1:0] top, input logic tcin);
        a = ta; b = tb2; op = top; cin = tcin; tag_in = 4'h3;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_cycle1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("lat_cycle2", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic send64(input logic [63:0] ta, input logic [63:0] tb2,
                          input logic [1:0] top, input logic tcin);
        w_a = ta; w_b = tb2; w_op = top; w_cin = tcin; w_tag_in = 4'h7;
        w_in_valid = 1'b1; w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("w_valid", {63'd0, w_out_valid}, 64'd1);
    endtask

    int         sent, retired;
    logic       held, dup, stale;
    logic [31:0] snap_sum;
    logic [3:0]  snap_tag;

    initial begin
        rst = 1'b1;
        in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0; cin = 0; tag_in = 0;
        w_in_valid = 0; w_out_ready = 0; w_a = 0; w_b = 0; w_op = 0; w_cin = 0; w_tag_in = 0;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_flags", {59'd0, c_out, ovf, zero, neg, 1'b0}, 64'd0);
        chk("rst_tag", {60'd0, tag_out}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // group-boundary carry
        send32(32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0);
        chk("gb_sum", {32'd0, sum}, 64'h0001_0000);
        chk("gb_flags", {60'd0, c_out, ovf, zero, neg}, 64'b0000);
        chk("gb_tag", {60'd0, tag_out}, 64'h3);

        // full wrap to zero
        send32(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0);
        chk("wrap_sum", {32'd0, sum}, 64'd0);
        chk("wrap_flags", {60'd0, c_out, ovf, zero, neg}, 64'b1010);

        // 5 - 7: borrow, negative
        send32(32'd5, 32'd7, 2'b01, 1'b0);
        chk("sub_sum", {32'd0, sum}, 64'hFFFF_FFFE);
        chk("sub_flags", {60'd0, c_out, ovf, zero, neg}, 64'b0001);

        // 7 - 5 with cin=0 ignored
        send32(32'd7, 32'd5, 2'b01, 1'b0);
        chk("sub2_sum", {32'd0, sum}, 64'd2);
        chk("sub2_cout", {63'd0, c_out}, 64'd1);

        // add with carry-in
        send32(32'd1, 32'd1, 2'b00, 1'b1);
        chk("cin_sum", {32'd0, sum}, 64'd3);

        // positive overflow with saturate request
        send32(32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 1'b0);
`ifdef CLA_SAT_EN
        chk("satp_sum", {32'd0, sum}, 64'h7FFF_FFFF);
        chk("satp_flags", {60'd0, c_out, ovf, zero, neg}, 64'b0100);
`else
        chk("satp_sum", {32'd0, sum}, 64'h8000_0000);
        chk("satp_flags", {60'd0, c_out, ovf, zero, neg}, 64'b0101);
`endif

        // negative overflow with saturate request
        send32(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0);
`ifdef CLA_SAT_EN
        chk("satn_sum", {32'd0, sum}, 64'h8000_0000);
        chk("satn_flags", {60'd0, c_out, ovf, zero, neg}, 64'b1101);
`else
        chk("satn_sum", {32'd0, sum}, 64'h7FFF_FFFF);
        chk("satn_flags", {60'd0, c_out, ovf, zero, neg}, 64'b1100);
`endif

        // drain, then stream tags 0..5 with out_ready low for cycles 3..5
        @(posedge clk); #1;
        sent = 0; retired = 0; held = 0; dup = 0;
        snap_sum = '0; snap_tag = '0;
        for (int k = 0; k < 40; k++) begin
            if (retired == 6) break;
            out_ready = !(k >= 3 && k <= 5);
            in_valid  = (sent < 6);
            a = 32'(sent * 256); b = 32'(sent); op = 2'b00; cin = 1'b0;
            tag_in = 4'(sent);
            #1;
            if (k == 3) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            if (out_valid && !out_ready) begin
                if (held) begin
                    chk("hold_sum", {32'd0, sum}, {32'd0, snap_sum});
                    chk("hold_tag", {60'd0, tag_out}, {60'd0, snap_tag});
                end else begin
                    held = 1'b1; snap_sum = sum; snap_tag = tag_out;
                end
            end
            if (out_valid && out_ready) begin
                chk("order_tag", {60'd0, tag_out}, 64'(retired));
                chk("order_sum", {32'd0, sum}, 64'(retired * 32'h101));
                retired++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        chk("stream_retired", 64'(retired), 64'd6);
        chk("stream_sent", 64'(sent), 64'd6);
        in_valid = 1'b0;
        repeat (3) begin
            if (out_valid) dup = 1'b1;
            @(posedge clk); #1;
        end
        chk("no_dup", {63'd0, dup}, 64'd0);

        // reset with two bundles in flight
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd9; tag_in = 4'd9;
        @(posedge clk); #1;
        a = 32'd10; tag_in = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_full", {62'd0, out_valid, in_ready}, 64'b10);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_sum", {32'd0, sum}, 64'd0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale", {63'd0, stale}, 64'd0);

        // 64-bit, 8-bit groups
        send64(64'h00FF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0);
        chk("w_ripple_sum", w_sum, 64'h0100_0000_0000_0000);
        chk("w_ripple_flags", {60'd0, w_c_out, w_ovf, w_zero, w_neg}, 64'b0000);
        send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0);
        chk("w_wrap_sum", w_sum, 64'd0);
        chk("w_wrap_flags", {60'd0, w_c_out, w_ovf, w_zero, w_neg}, 64'b1010);
        send64(64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b0);
        chk("w_sub_sum", w_sum, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("w_sub_flags", {60'd0, w_c_out, w_ovf, w_zero, w_neg}, 64'b1100);
        send64(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 2'b00, 1'b0);
        chk("w_mix_sum", w_sum, 64'h1234_5678_9ABC_DF00);
        chk("w_mix_tag", {60'd0, w_tag_out}, 64'h7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
